// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, runs the SRAM req/resp handshake, feeds IF/ID.
// Latency: one instruction per 3 cycles minimum (REQ->WAIT->HOLD) on a zero-latency bus; one request in flight.
// Backpressure: holds the fetched instruction while IF_ID_allowin=0; redirects are latched until the bus is idle.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   br_valid/br_target          branch redirect pulse and target
//   flush_valid/flush_target    exception/ERET flush pulse and target (beats a branch)
//   inst_req/inst_addr          SRAM request, address held until inst_addr_ok
//   inst_addr_ok/inst_data_ok   SRAM request accept / response valid
//   inst_rdata                  SRAM response data
//   IF_ID_allowin               downstream can take an instruction
//   fs_valid/fs_pc/fs_inst      instruction presented to IF/ID
//   fs_excp                     fetch-address exception flag
//
// Optional feature (macro ADEF_CHECK_EN): misaligned fetch PCs raise fs_excp instead
// of issuing a bus request. Without the macro fs_excp stays 0.

module fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush_valid,
    input  logic [ADDR_W-1:0] flush_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [ADDR_W-1:0] inst_rdata,
    input  logic              IF_ID_allowin,
    output logic              fs_valid,
    output logic [ADDR_W-1:0] fs_pc,
    output logic [ADDR_W-1:0] fs_inst,
    output logic              fs_excp
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_CANCEL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              pend_valid;
    logic              pend_flush;
    logic [ADDR_W-1:0] pend_target;

    logic              take_arr;
    logic              redir_vld;
    logic              redir_flush;
    logic [ADDR_W-1:0] redir_target;
    logic              misalign;

`ifdef ADEF_CHECK_EN
    assign misalign = (pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Effective redirect this cycle: an arriving flush always wins, an arriving
    // branch wins unless a flush is already pending.
    always_comb begin
        take_arr     = flush_valid | (br_valid & ~(pend_valid & pend_flush));
        redir_vld    = take_arr | pend_valid;
        redir_target = pend_target;
        redir_flush  = pend_flush;
        if (take_arr) begin
            redir_target = flush_valid ? flush_target : br_target;
            redir_flush  = flush_valid;
        end
    end

    assign inst_req  = (state == S_REQ) & ~misalign;
    assign inst_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_flush  <= 1'b0;
            pend_target <= '0;
            fs_valid    <= 1'b0;
            fs_excp     <= 1'b0;
            fs_pc       <= '0;
            fs_inst     <= '0;
        end else begin
            // Keep the strongest redirect seen so far; branches that act on it
            // clear pend_valid below.
            pend_valid  <= redir_vld;
            pend_flush  <= redir_flush;
            pend_target <= redir_target;

            case (state)
                S_REQ: begin
                    if (misalign) begin
                        if (redir_vld) begin
                            pc         <= redir_target;
                            pend_valid <= 1'b0;
                        end else begin
                            state    <= S_HOLD;
                            fs_valid <= 1'b1;
                            fs_excp  <= 1'b1;
                            fs_pc    <= pc;
                            fs_inst  <= '0;
                        end
                    end else if (inst_addr_ok) begin
                        // A redirect already seen means the response is stale.
                        state <= redir_vld ? S_CANCEL : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (redir_vld) begin
                            pc         <= redir_target;
                            pend_valid <= 1'b0;
                            state      <= S_REQ;
                        end else begin
                            fs_valid <= 1'b1;
                            fs_pc    <= pc;
                            fs_inst  <= inst_rdata;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_CANCEL: begin
                    if (inst_data_ok) begin
                        pc         <= redir_target;
                        pend_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (redir_vld) begin
                        // Buffered instruction is dropped even if allowin is high.
                        fs_valid   <= 1'b0;
                        fs_excp    <= 1'b0;
                        pc         <= redir_target;
                        pend_valid <= 1'b0;
                        state      <= S_REQ;
                    end else if (IF_ID_allowin && !fs_excp) begin
                        fs_valid <= 1'b0;
                        pc       <= pc + ADDR_W'(4);
                        state    <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: transaction-level reference model plus directed literal checks.
// Inputs change on the falling edge; outputs are compared on the falling edge before new inputs apply.
// The bench acts as the instruction SRAM and as the IF/ID stage.

module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_target = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        IF_ID_allowin = 1'b0;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_excp;

    fetch_ctrl #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .br_valid     (br_valid),
        .br_target    (br_target),
        .flush_valid  (flush_valid),
        .flush_target (flush_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .IF_ID_allowin(IF_ID_allowin),
        .fs_valid     (fs_valid),
        .fs_pc        (fs_pc),
        .fs_inst      (fs_inst),
        .fs_excp      (fs_excp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch pointer, one outstanding bus transaction, a one-entry
    // output buffer and a pending redirect with priority 0=none, 1=branch, 2=flush.
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_buf;
    bit          m_excp;
    logic [31:0] m_bpc;
    logic [31:0] m_binst;
    int          m_pp;
    logic [31:0] m_pt;

    bit          bus_out = 1'b0;   // SRAM side: a request was accepted and not yet answered
    logic [31:0] acc_q[$];         // every address the SRAM accepted

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [31:0] exp);
        if (idx < acc_q.size()) chk(name, acc_q[idx], exp);
        else begin
            checks++;
            errors++;
            $display("FAIL %s: no accepted request, expected %h", name, exp);
        end
    endtask

    function automatic bit m_mis();
`ifdef ADEF_CHECK_EN
        return m_pc[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare();
        bit exp_req;
        exp_req = !m_busy && !m_buf && !m_mis();
        chk("inst_req", inst_req, exp_req);
        if (exp_req) chk("inst_addr", inst_addr, m_pc);
        chk("fs_valid", fs_valid, m_buf);
        if (m_buf) begin
            chk("fs_pc", fs_pc, m_bpc);
            chk("fs_inst", fs_inst, m_binst);
        end
        chk("fs_excp", fs_excp, m_excp);
    endtask

    task automatic model_step(input bit aok, input bit dok, input bit allow,
                              input bit br, input logic [31:0] brt,
                              input bit fl, input logic [31:0] flt,
                              input logic [31:0] rdata);
        int          a;
        bit          e_vld;
        int          e_p;
        logic [31:0] e_tgt;
        a     = fl ? 2 : (br ? 1 : 0);
        e_vld = (a != 0 && a >= m_pp) || m_pp != 0;
        e_p   = (a != 0 && a >= m_pp) ? a : m_pp;
        e_tgt = (a != 0 && a >= m_pp) ? (fl ? flt : brt) : m_pt;
        if (m_buf) begin
            if (e_vld) begin
                m_buf = 0; m_excp = 0; m_pc = e_tgt; m_pp = 0;
            end else if (allow && !m_excp) begin
                m_buf = 0; m_pc = m_pc + 32'd4;
            end
        end else if (m_busy) begin
            if (dok) begin
                m_busy = 0;
                if (e_vld) begin
                    m_pc = e_tgt; m_pp = 0;
                end else begin
                    m_buf = 1; m_bpc = m_pc; m_binst = rdata;
                end
            end else begin
                m_pp = e_p; m_pt = e_tgt;
            end
        end else if (m_mis()) begin
            if (e_vld) begin
                m_pc = e_tgt; m_pp = 0;
            end else begin
                m_buf = 1; m_excp = 1; m_bpc = m_pc; m_binst = '0;
            end
        end else begin
            if (aok) m_busy = 1;
            m_pp = e_p; m_pt = e_tgt;
        end
    endtask

    // One clock: compare, drive inputs, advance the model, wait for the next falling edge.
    task automatic step(input bit aok, input bit dok, input bit allow,
                        input bit br, input logic [31:0] brt,
                        input bit fl, input logic [31:0] flt);
        logic [31:0] rdata;
        compare();
        rdata         = $urandom;
        inst_addr_ok  = aok;
        inst_data_ok  = dok;
        inst_rdata    = rdata;
        IF_ID_allowin = allow;
        br_valid      = br;
        br_target     = brt;
        flush_valid   = fl;
        flush_target  = flt;
        if (inst_req && aok) acc_q.push_back(inst_addr);
        model_step(aok, dok, allow, br, brt, fl, flt, rdata);
        if (dok) bus_out = 1'b0;
        if (inst_req && aok) bus_out = 1'b1;
        @(negedge clk);
    endtask

    // Zero-latency bus: accept every request, answer the next cycle.
    task automatic auto(input int n, input bit allow);
        for (int i = 0; i < n; i++) step(inst_req, bus_out, allow, 1'b0, '0, 1'b0, '0);
    endtask

    // Asserted on a falling edge; reset values must appear without a clock edge.
    task automatic do_reset();
        rst          = 1'b1;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        br_valid     = 1'b0;
        flush_valid  = 1'b0;
        IF_ID_allowin = 1'b0;
        #1;
        chk("rst_inst_req", inst_req, 32'd1);
        chk("rst_inst_addr", inst_addr, 32'h8000_0000);
        chk("rst_fs_valid", fs_valid, 32'd0);
        chk("rst_fs_excp", fs_excp, 32'd0);
        chk("rst_fs_inst", fs_inst, 32'd0);
        m_pc = RST_PC; m_busy = 0; m_buf = 0; m_excp = 0; m_pp = 0; m_pt = '0;
        m_bpc = '0; m_binst = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        case ($urandom_range(0, 7))
            0:       t = 32'hFFFF_FFFC;
            1:       t = 32'h8000_0380;
            2:       t = 32'h8000_1000;
            default: t = $urandom & 32'hFFFF_FFFC;
        endcase
`ifdef ADEF_CHECK_EN
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
`endif
        return t;
    endfunction

    initial begin
        int mark;
        bit aok, dok, allow, br, fl;

        @(negedge clk);

        // Sequential fetch on a zero-latency bus.
        do_reset();
        mark = acc_q.size();
        auto(9, 1'b1);
        chk_acc("seq0", mark,     32'h8000_0000);
        chk_acc("seq1", mark + 1, 32'h8000_0004);
        chk_acc("seq2", mark + 2, 32'h8000_0008);

        // Backpressure in HOLD, then resume at pc+4.
        auto(2, 1'b1);
        mark = acc_q.size();
        auto(5, 1'b0);
        chk("hold_fs_pc", fs_pc, 32'h8000_000C);
        auto(3, 1'b1);
        chk_acc("after_hold", mark, 32'h8000_0010);

        // Branch in REQ with a slow addr_ok: address held, response discarded.
        do_reset();
        auto(3, 1'b1);
        mark = acc_q.size();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        auto(1, 1'b1);
        chk_acc("br_req_held", mark,     32'h8000_0004);
        chk_acc("br_req_tgt",  mark + 1, 32'h8000_1000);

        // Branch and flush in the same WAIT cycle.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b1, 32'h8000_0380);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        mark = acc_q.size();
        auto(1, 1'b1);
        chk_acc("br_fl_same", mark, 32'h8000_0380);

        // Pending branch overwritten by a later flush.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h8000_0380);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        mark = acc_q.size();
        auto(1, 1'b1);
        chk_acc("br_then_fl", mark, 32'h8000_0380);

        // Pending flush survives a later branch.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h8000_0380);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        mark = acc_q.size();
        auto(1, 1'b1);
        chk_acc("fl_then_br", mark, 32'h8000_0380);

        // Reset while in WAIT, then a stale data_ok.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        mark = acc_q.size();
        auto(3, 1'b1);
        chk_acc("rst_wait_first", mark, 32'h8000_0000);
        chk("rst_wait_fs_pc", fs_pc, 32'h8000_0000);

        // PC wraps from FFFFFFFC to 0.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        mark = acc_q.size();
        auto(4, 1'b1);
        chk_acc("wrap_last", mark,     32'hFFFF_FFFC);
        chk_acc("wrap_zero", mark + 1, 32'h0000_0000);

`ifdef ADEF_CHECK_EN
        // Misaligned redirect target: exception presented, allowin alone cannot leave.
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_1002, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("adef_valid", fs_valid, 32'd1);
        chk("adef_excp", fs_excp, 32'd1);
        chk("adef_pc", fs_pc, 32'h8000_1002);
        auto(3, 1'b1);
        chk("adef_hold_excp", fs_excp, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h8000_0380);
        chk("adef_req", inst_req, 32'd1);
        chk("adef_addr", inst_addr, 32'h8000_0380);
        chk("adef_clr", fs_excp, 32'd0);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                aok   = inst_req && ($urandom_range(0, 2) != 0);
                dok   = bus_out ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
                allow = ($urandom_range(0, 4) < 3);
                br    = ($urandom_range(0, 11) == 0);
                fl    = ($urandom_range(0, 24) == 0);
                step(aok, dok, allow, br, rand_tgt(), fl, rand_tgt());
            end
        end
        compare();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the pipeline front end.
- Owns the fetch PC and generates the next PC from three sources: sequential (PC+4), branch redirect, and exception/ERET flush.
- Drives the instruction-SRAM request/response handshake and presents each fetched instruction to IF/ID with a valid/allowin handshake.
- Sits between the EX/WB redirect sources and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h80000000, fetch address used after reset.
- ADDR_W, 32, PC and instruction width.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous, active-high.
- br_valid  input  1  branch redirect request (single-cycle pulse).
- br_target  input  32  branch target, sampled when br_valid=1.
- flush_valid  input  1  exception/ERET flush (single-cycle pulse); higher priority than br_valid.
- flush_target  input  32  flush target, sampled when flush_valid=1.
- inst_req  output  1  instruction SRAM request.
- inst_addr  output  32  request address; stable while inst_req=1.
- inst_addr_ok  input  1  request accepted this cycle.
- inst_data_ok  input  1  response data valid this cycle.
- inst_rdata  input  32  response data.
- IF_ID_allowin  input  1  IF/ID can accept an instruction.
- fs_valid  output  1  fs_pc/fs_inst valid toward IF/ID.
- fs_pc  output  32  PC of the presented instruction.
- fs_inst  output  32  presented instruction.
- fs_excp  output  1  fetch-address exception flag (0 when ADEF_CHECK_EN is undefined).

Behaviour:
- Reset (async, while rst=1):
  - state=REQ, pc=RESET_PC.
  - pend_valid=0.
  - fs_valid=0, fs_excp=0, fs_inst=0.
  - inst_req is combinational from state, so it is 1 in the first cycle after rst falls. Both inst_req=1 and inst_addr=RESET_PC hold during reset.
- State register, FSM REQ/WAIT/HOLD/CANCEL:
  - REQ: inst_req=1, inst_addr=pc. On addr_ok=1: go to CANCEL if a redirect is pending or arriving this cycle, else WAIT. inst_addr must not change before addr_ok, so a redirect seen in REQ is latched into pend.
  - WAIT: inst_req=0. On data_ok=1 with no redirect pending or arriving: fs_inst<=rdata, fs_pc<=pc, fs_valid<=1, go to HOLD. On data_ok=1 with a redirect: discard the data, pc<=redirect target, pend_valid<=0, go to REQ.
  - HOLD: fs_valid=1; fs_pc and fs_inst stay stable.
    - IF_ID_allowin=1 and no redirect: fs_valid<=0, pc<=pc+4 (mod 2^32, wraps FFFFFFFC->00000000), go to REQ.
    - Redirect arriving in HOLD: fs_valid<=0, pc<=target, go to REQ. The buffered instruction is dropped even if allowin=1 in the same cycle.
  - CANCEL: inst_req=0. Wait for data_ok, discard the data, then pc<=pend target, pend_valid<=0, go to REQ.
- Redirect priority and latching:
  - Same cycle: flush beats br.
  - A new flush overwrites a pending br.
  - A new br never overwrites a pending flush.
  - A new br overwrites a pending br.
  - An arriving redirect beats a pending one of equal or lower priority.
- Throughput: one instruction per 3 cycles minimum (REQ->WAIT->HOLD) with a zero-latency bus. No outstanding-request overlap; at most one request is in flight.
- data_ok is ignored in REQ and HOLD (no request outstanding).
- Reset mid-operation: all state, including any pending redirect and buffered instruction, is cleared immediately. Fetch restarts at RESET_PC.

Optional Feature:
- Macro: ADEF_CHECK_EN.
- Defined:
  - In REQ, if pc[1:0]!=2'b00, no bus request is issued (inst_req=0). The FSM moves straight to HOLD with fs_excp=1, fs_pc=pc, fs_inst=0.
  - In HOLD with fs_excp=1, IF_ID_allowin does not advance the PC; only a redirect leaves HOLD.
  - fs_excp clears when HOLD is left.
- Undefined: fs_excp is tied to 0 and misaligned PCs are requested unchanged.

Test Plan:
- Reset release, bus returns addr_ok and data_ok one cycle after each request, allowin=1 -> inst_addr sequence 80000000, 80000004, 80000008. fs_valid pulses with fs_pc matching and fs_inst=rdata.
- allowin=0 for 5 cycles in HOLD -> fs_valid, fs_pc and fs_inst are stable, no new inst_req. Then allowin=1 -> next request at pc+4.
- br_valid with br_target=80001000 while in REQ, addr_ok delayed 3 cycles -> inst_addr stays 80000004 until accepted. The response is discarded (fs_valid stays 0), then a request to 80001000 is issued.
- br_valid (80001000) and flush_valid (80000380) in the same WAIT cycle -> next request address is 80000380. Also: br pending, then a later flush -> 80000380. Flush pending, then a later br -> 80000380.
- rst asserted while in WAIT -> outputs return to reset values immediately (inst_req=1, fs_valid=0). A subsequent stale data_ok is ignored; the first accepted request is to 80000000.
- ADEF_CHECK_EN defined, br_target=80001002 -> no inst_req, fs_valid=1, fs_excp=1, fs_pc=80001002. allowin alone holds the state. flush_valid with flush_target=80000380 -> request to 80000380, fs_excp=0.
